// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths and the pooling FSM state type.
package npu_pkg;

  localparam int ACC_W = 22;
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

endpackage

// File: rtl/pool_relu_2x2_requant_sat.sv
// requant_sat: arithmetic right shift of a pooled accumulator value, then
// saturation to the 8-bit output range. Build macro POOL_RELU_EN selects
// ReLU + unsigned 0..255 saturation; otherwise signed -128..127 output.
module requant_sat
  import npu_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] p_i,
  output logic        [OUT_W-1:0] q_o
);

  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-128);

  logic signed [ACC_W-1:0] shifted;

  assign shifted = p_i >>> SHIFT;

  // Clamp the shifted value into the output code range.
  always_comb begin
    q_o = '0;
`ifdef POOL_RELU_EN
    // A negative p always shifts to a negative value, so its sign bit is the ReLU test.
    if (shifted[ACC_W-1])     q_o = '0;
    else if (shifted > U_MAX) q_o = '1;
    else                      q_o = shifted[OUT_W-1:0];
`else
    if (shifted > S_MAX)      q_o = S_MAX[OUT_W-1:0];
    else if (shifted < S_MIN) q_o = S_MIN[OUT_W-1:0];
    else                      q_o = shifted[OUT_W-1:0];
`endif
  end

endmodule

// File: rtl/pool_relu_2x2.sv
// pool_relu_2x2: streaming 2x2 max-pool over a conv result frame, followed by
// requantization (see requant_sat; build macro POOL_RELU_EN enables ReLU).
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting conv results, pooling on odd rows / odd columns
//   DRAIN | input finished, waiting for the output pipeline to empty
//   DONE  | one-cycle frame-complete pulse
module pool_relu_2x2
  import npu_pkg::*;
#(
  parameter int IN_W  = 30,
  parameter int IN_H  = 30,
  parameter int SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_done,
  output logic        [OUT_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    done
);

  localparam int XW      = (IN_W > 2) ? $clog2(IN_W) : 2;
  localparam int YW      = (IN_H > 2) ? $clog2(IN_H) : 1;
  localparam int BUF_N   = IN_W / 2;
  localparam int LAST_PX = 2 * (IN_W / 2) - 1;
  localparam int LAST_PY = 2 * (IN_H / 2) - 1;

  pool_state_t state_q, state_d;

  logic [XW-1:0]           x_q;
  logic [YW-1:0]           y_q;
  logic signed [ACC_W-1:0] hold_q;
  logic signed [ACC_W-1:0] row_buf [BUF_N];

  logic                    s1_valid_q, s1_last_q;
  logic signed [ACC_W-1:0] s1_p_q;
  logic                    s2_valid_q, s2_last_q;
  logic [OUT_W-1:0]        s2_q;
  logic [OUT_W-1:0]        out_data_q;
  logic                    out_valid_q, out_last_q;

  logic                    accept, x_end, y_end, pix_done, last_px;
  logic signed [ACC_W-1:0] m, bufv, p;
  logic [OUT_W-1:0]        rq;

  assign accept   = in_valid && (state_q == RUN);
  assign x_end    = (x_q == XW'(IN_W - 1));
  assign y_end    = (y_q == YW'(IN_H - 1));
  // Odd x on an odd row completes a 2x2 window; a trailing even column/row never does.
  assign pix_done = accept && x_q[0] && y_q[0];
  assign last_px  = (x_q == XW'(LAST_PX)) && (y_q == YW'(LAST_PY));

  assign m    = (in_data > hold_q) ? in_data : hold_q;
  assign bufv = row_buf[x_q[XW-1:1]];
  assign p    = (m > bufv) ? m : bufv;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and frame-complete pulse.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if ((accept && x_end && y_end) || in_done) state_d = DRAIN;
      DRAIN: if (!s1_valid_q && !s2_valid_q && !out_valid_q) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Column/row position and even-column hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      hold_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (!x_q[0]) hold_q <= in_data;
      if (x_end) begin
        x_q <= '0;
        y_q <= y_end ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Even rows store pair maxima; every entry is rewritten before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && x_q[0] && !y_q[0]) row_buf[x_q[XW-1:1]] <= m;
  end

  requant_sat #(.SHIFT(SHIFT)) u_requant (
    .p_i (s1_p_q),
    .q_o (rq)
  );

  // Three-stage output pipeline: pooled max, requantized code, output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_p_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= pix_done;
      s1_last_q   <= pix_done && last_px;
      s1_p_q      <= p;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_q        <= rq;
      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_valid_q && s2_last_q;
      out_data_q  <= s2_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_relu_2x2.sv
// Bench for pool_relu_2x2: frame-level pooling model, per-cycle output compare,
// directed frames (ramp, constants, bubbles, truncation, mid-frame reset).
module tb_pool_relu_2x2;
  import npu_pkg::*;

  localparam int W  = 30;
  localparam int H  = 30;
  localparam int SH = 4;
`ifdef POOL_RELU_EN
  localparam int NEG_EXP = 0;
  localparam int BIG_EXP = 255;
`else
  localparam int NEG_EXP = 249;
  localparam int BIG_EXP = 127;
`endif

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_done;
  logic signed [21:0] in_data;
  logic [7:0]        out_data;
  logic              out_valid, out_last, done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pool_relu_2x2 #(.IN_W(W), .IN_H(H), .SHIFT(SH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_done   (in_done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .done      (done)
  );

  typedef struct {
    int data;
    bit last;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   got_q[$];
  int   ramp_ref[$];
  int   total = 0, bad = 0;
  int   last_cnt = 0, last_cyc = 0, done_cnt = 0, done_cyc = 0;

  function automatic int val(input int kind, input int x, input int y);
    if (kind == 0)      return 16 * (W * y + x);
    else if (kind == 1) return -100;
    else                return 100000;
  endfunction

  // Max of the 2x2 window, floor-shift, then clamp to the output code.
  function automatic int pooled(input int kind, input int i, input int j);
    int mx, s;
    mx = val(kind, 2*i, 2*j);
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if (val(kind, 2*i+dx, 2*j+dy) > mx) mx = val(kind, 2*i+dx, 2*j+dy);
    s = mx >>> SH;
`ifdef POOL_RELU_EN
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    return s;
`else
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s & 255;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_cycle();
    exp_t e;
    if (out_valid) begin
      got_q.push_back(int'(out_data));
      if (out_last) begin
        last_cnt++;
        last_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        chk("out_valid_nothing_pending", int'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_last", int'(out_last), int'(e.last));
        chk("out_latency", cyc - e.cyc, 2);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic run_frame(input int kind, input int bubble_pct, input int n_in,
                           input bit send_done, input bit wait_done);
    int idx, guard, x, y, v, k, base;
    // in_valid while IDLE must be ignored
    v = 777;
    in_valid = 1'b1;
    in_data  = v[21:0];
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < n_in && guard < 20000) begin
      x = idx % W;
      y = idx / W;
      guard++;
      if (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
        v = 5555;
        in_data = v[21:0];
        start = ($urandom_range(3) == 0);
      end else begin
        in_valid = 1'b1;
        v = val(kind, x, y);
        in_data = v[21:0];
      end
      @(posedge clk);
      #1;
      if (in_valid) begin
        if (x % 2 == 1 && y % 2 == 1)
          exp_q.push_back('{pooled(kind, x/2, y/2),
                            (x == 2*(W/2)-1) && (y == 2*(H/2)-1), cyc});
        idx++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
    end
    chk("input_guard", guard < 20000, 1);
    if (send_done) begin
      in_done = 1'b1;
      @(posedge clk);
      #1;
      in_done = 1'b0;
    end
    if (wait_done) begin
      base = done_cnt;
      k = 0;
      while (done_cnt == base && k < 40) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("done_pulse_count", done_cnt - base, 1);
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_check(input string tag, input int n_exp, input int last_exp,
                             input int first_exp);
    chk({tag, "_count"}, got_q.size(), n_exp);
    chk({tag, "_last_count"}, last_cnt, last_exp);
    chk({tag, "_first"}, (got_q.size() > 0) ? got_q[0] : -1, first_exp);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_state_idle"}, int'(dut.state_q), int'(IDLE));
    if (last_exp > 0) chk({tag, "_done_after_last"}, done_cyc - last_cyc, 2);
  endtask

  task automatic clear_frame();
    got_q.delete();
    last_cnt = 0;
  endtask

  task automatic seq_vs_ref(input string tag);
    int nm;
    nm = 0;
    for (int i = 0; i < ramp_ref.size(); i++)
      if (i >= got_q.size() || got_q[i] != ramp_ref[i]) nm++;
    chk({tag, "_seq_diff"}, nm, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_done = 1'b0; in_data = '0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_state", int'(dut.state_q), int'(IDLE));
    rst = 1'b0;

    // ramp, continuous valid
    clear_frame();
    run_frame(0, 0, W*H, 0, 1);
    frame_check("ramp", 225, 1, 31);
    chk("ramp_second", (got_q.size() > 1) ? got_q[1] : -1, 33);
    chk("ramp_final", (got_q.size() > 224) ? got_q[224] : -1, BIG_EXP);
    ramp_ref = got_q;

    // constant negative input
    clear_frame();
    run_frame(1, 0, W*H, 0, 1);
    frame_check("neg", 225, 1, NEG_EXP);

    // constant large input
    clear_frame();
    run_frame(2, 0, W*H, 0, 1);
    frame_check("big", 225, 1, BIG_EXP);

    // ramp with ~50% bubbles and stray start pulses
    clear_frame();
    run_frame(0, 50, W*H, 0, 1);
    frame_check("bubble", 225, 1, 31);
    seq_vs_ref("bubble");

    // truncated after 10 rows
    clear_frame();
    run_frame(0, 0, 10*W, 1, 1);
    frame_check("trunc", 75, 0, 31);

    // reset in row 7, then a full frame
    run_frame(0, 0, 7*W + 5, 0, 0);
    rst = 1'b1;
    exp_q.delete();
    clear_frame();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    start = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    chk("midrst_state", int'(dut.state_q), int'(IDLE));
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_outputs", got_q.size(), 0);
    chk("midrst_state_after", int'(dut.state_q), int'(IDLE));
    clear_frame();
    run_frame(0, 0, W*H, 0, 1);
    frame_check("after_rst", 225, 1, 31);
    seq_vs_ref("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
